// File: rtl/piso_feeder.sv
// piso_feeder: parallel-in/serial-out feeder for a downstream right-shift
// register. Optional macro: PISO_BACK2BACK_EN (zero-gap word reload).
//
// Ports:
//   clk, clrb             clock, synchronous active-low reset
//   load_valid, pdata     upstream word handshake (valid side)
//   load_ready            feeder can accept a word this cycle
//   sdr, sdr_valid        serial bit (LSB first) and its qualifier
//   bit_idx               index of the bit currently on sdr
//   busy, done            shifting flag, one-cycle word-complete pulse
module piso_feeder #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     clrb,
    input  logic                     load_valid,
    input  logic [WIDTH-1:0]         pdata,
    output logic                     load_ready,
    output logic                     sdr,
    output logic                     sdr_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             xfer;

    assign last = (state == SHIFT) && (cnt == LAST);

    // Ready depends only on state and reset, never on load_valid.
`ifdef PISO_BACK2BACK_EN
    assign load_ready = clrb && ((state == IDLE) || last);
`else
    assign load_ready = clrb && (state == IDLE);
`endif

    assign xfer = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!clrb) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer) begin
                sreg  <= pdata;
                cnt   <= '0;
                state <= SHIFT;
                // A reload on the last bit still completes the old word.
                if (last)
                    done <= 1'b1;
            end else if (state == SHIFT) begin
                if (last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + CW'(1);
                end
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign sdr_valid = (state == SHIFT);
    assign sdr       = (state == SHIFT) && sreg[0];
    assign bit_idx   = (state == SHIFT) ? cnt : '0;

endmodule

// File: tb/tb_piso_feeder.sv
// tb_piso_feeder: directed scoreboard bench for piso_feeder (WIDTH 4 and 8)
// with a model of the downstream {sdr, q[3:1]} register.
module tb_piso_feeder;

    logic       clk = 1'b0;
    logic       clrb;
    logic       lv;
    logic [3:0] pd;
    logic       ready, sdr, sdr_valid, busy, done;
    logic [1:0] bit_idx;

    logic       lv8;
    logic [7:0] pd8;
    logic       ready8, sdr8, sdr_valid8, busy8, done8;
    logic [2:0] bit_idx8;

    logic [3:0] q = 4'h0;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    typedef struct {
        logic       b;
        logic [1:0] i;
        int         c;
    } bit_t;

    typedef struct {
        logic [3:0] w;
        int         c;
    } word_t;

    bit_t  bq[$];
    word_t dq[$];

    piso_feeder #(.WIDTH(4)) dut (
        .clk(clk), .clrb(clrb), .load_valid(lv), .pdata(pd),
        .load_ready(ready), .sdr(sdr), .sdr_valid(sdr_valid),
        .bit_idx(bit_idx), .busy(busy), .done(done)
    );

    piso_feeder #(.WIDTH(8)) dut8 (
        .clk(clk), .clrb(clrb), .load_valid(lv8), .pdata(pd8),
        .load_ready(ready8), .sdr(sdr8), .sdr_valid(sdr_valid8),
        .bit_idx(bit_idx8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        q   <= {sdr, q[3:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard as bits and done pulses appear.
    always @(negedge clk) begin
        if (sdr_valid) begin
            if (bq.size() == 0) begin
                chk("unexpected_bit", 32'(sdr_valid), 32'd0);
            end else begin
                bit_t e;
                e = bq.pop_front();
                chk("sdr", 32'(sdr), 32'(e.b));
                chk("bit_idx", 32'(bit_idx), 32'(e.i));
                chk("bit_cycle", 32'(cyc), 32'(e.c));
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                word_t d;
                d = dq.pop_front();
                chk("q_at_done", 32'(q), 32'(d.w));
                chk("done_cycle", 32'(cyc), 32'(d.c));
            end
        end
    end

    // Present a word and hold it until accepted; returns #1 after the
    // handshake edge with the expected stream pushed.
    task automatic send(input logic [3:0] w, output int hs);
        int n;
        logic [3:0] v;
        pd = w;
        lv = 1'b1;
        n = 0;
        hs = -1;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("handshake_timeout", 32'(ready), 32'd1);
            lv = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            lv = 1'b0;
            hs = cyc;
            v = w;
            for (int i = 0; i < 4; i++)
                bq.push_back('{b: v[i], i: 2'(i), c: hs + i});
            dq.push_back('{w: w, c: hs + 4});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || dq.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bits", 32'(bq.size()), 32'd0);
        chk("drain_done", 32'(dq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h1, h2;
        logic [7:0] w8;

        // Reset held with a word presented: nothing may move.
        clrb = 1'b0;
        lv   = 1'b1;
        pd   = 4'hF;
        lv8  = 1'b0;
        pd8  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_sdr", 32'(sdr), 32'd0);
            chk("rst_sdr_valid", 32'(sdr_valid), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
        end
        lv = 1'b0;
        clrb = 1'b1;
        #1;
        chk("ready_after_rst", 32'(ready), 32'd1);
        chk("busy_after_rst", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Single word.
        send(4'b1011, h1);
        drain();

        // Busy ignore: second word offered during bit 1 is dropped.
        send(4'b1011, h1);
        @(posedge clk);
        #1;
        lv = 1'b1;
        pd = 4'h0;
        chk("busy_ready", 32'(ready), 32'd0);
        chk("busy_flag", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        lv = 1'b0;
        drain();

        // Reset mid-word at bit 2 of 4'hA.
        send(4'hA, h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        clrb = 1'b0;
        @(posedge clk);
        #1;
        bq.delete();
        dq.delete();
        chk("midrst_sdr_valid", 32'(sdr_valid), 32'd0);
        chk("midrst_sdr", 32'(sdr), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        clrb = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done), 32'd0);
        send(4'h5, h1);
        drain();

        // Back-to-back presentation of 4'h3 then 4'hC.
        send(4'h3, h1);
        send(4'hC, h2);
`ifdef PISO_BACK2BACK_EN
        chk("b2b_gap", 32'(h2 - h1), 32'd4);
`else
        chk("b2b_gap", 32'(h2 - h1), 32'd5);
`endif
        drain();

        // WIDTH=8 instance with 8'h96.
        w8  = 8'h96;
        pd8 = w8;
        lv8 = 1'b1;
        chk("w8_ready", 32'(ready8), 32'd1);
        @(posedge clk);
        #1;
        lv8 = 1'b0;
        pd8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("w8_valid", 32'(sdr_valid8), 32'd1);
            chk("w8_sdr", 32'(sdr8), 32'(w8[i]));
            chk("w8_idx", 32'(bit_idx8), 32'(i));
            chk("w8_early_done", 32'(done8), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("w8_done", 32'(done8), 32'd1);
        chk("w8_idle", 32'(sdr_valid8), 32'd0);
        @(posedge clk);
        #1;
        chk("w8_done_pulse", 32'(done8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
